// File: rtl/transpose_buffer_pp.sv
// Ping-pong transpose buffer: row-wise fetch beats fill one bank while the
// other bank is read out column by column under a ready/valid handshake.
module transpose_buffer_pp #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned NUM_ROWS    = 2,
  localparam int unsigned COL_W = (FETCH_WIDTH > 2) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FETCH_WIDTH*WORD_WIDTH-1:0] in_data,
  input  logic [FETCH_WIDTH-1:0]         in_mask,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [NUM_ROWS*WORD_WIDTH-1:0] out_pixels,
  output logic [COL_W-1:0]               out_col_index,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FETCH_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  logic [WORD_WIDTH-1:0] r_mem [2][NUM_ROWS][FETCH_WIDTH];
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ROW_W-1:0]      r_row_cnt;
  logic [COL_W-1:0]      r_col_cnt;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_out_last;
  logic       w_wr;
  logic       w_rd;
  logic       w_row_last;
  logic [1:0] w_full_nxt;

  assign w_in_ready  = !rst && !flush && !r_full[r_wr_bank];
  assign w_out_valid = r_full[r_rd_bank];
  assign w_out_last  = w_out_valid && (r_col_cnt == LAST_COL);
  assign w_wr        = in_valid && w_in_ready;
  assign w_rd        = w_out_valid && out_ready;
  assign w_row_last  = (r_row_cnt == LAST_ROW);

  assign in_ready      = w_in_ready;
  assign out_valid     = w_out_valid;
  assign out_last      = w_out_last;
  assign out_col_index = r_col_cnt;

  // Fill-complete and drain-complete always hit different banks, so both apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr && w_row_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd && w_out_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_comb begin
    out_pixels = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      out_pixels[r*WORD_WIDTH +: WORD_WIDTH] = r_mem[r_rd_bank][ROW_W'(r)][r_col_cnt];
    end
  end

  // Storage is intentionally left unreset; out_pixels is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        r_mem[r_wr_bank][r_row_cnt][COL_W'(i)] <=
          in_mask[i] ? in_data[i*WORD_WIDTH +: WORD_WIDTH] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr) begin
        if (w_row_last) begin
          r_wr_bank <= ~r_wr_bank;
          r_row_cnt <= '0;
        end else begin
          r_row_cnt <= r_row_cnt + ROW_W'(1);
        end
      end else if (flush) begin
        r_row_cnt <= '0;
      end
      if (w_rd) begin
        if (w_out_last) begin
          r_rd_bank <= ~r_rd_bank;
          r_col_cnt <= '0;
        end else begin
          r_col_cnt <= r_col_cnt + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_buffer_pp.sv
// Self-checking bench for transpose_buffer_pp: table-driven beats, a column
// scoreboard, and directed backpressure / overlap / flush / reset sequences.
module tb_transpose_buffer_pp;

  localparam int unsigned WW = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned CW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [FW*WW-1:0]  in_data;
  logic [FW-1:0]     in_mask;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [NR*WW-1:0]  out_pixels;
  logic [CW-1:0]     out_col_index;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  transpose_buffer_pp #(.WORD_WIDTH(WW), .FETCH_WIDTH(FW), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_mask(in_mask),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_pixels(out_pixels), .out_col_index(out_col_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW*WW-1:0] data;
    logic [FW-1:0]    mask;
    logic [FW*WW-1:0] exp_row;
  } vec_t;

  typedef struct {
    logic [NR*WW-1:0] pix;
    logic [CW-1:0]    idx;
    logic             last;
  } col_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  col_t             sb[$];
  logic [FW*WW-1:0] mrow [NR];
  int unsigned      mrows = 0;
  vec_t             tbl [6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [FW*WW-1:0] mkrow(input logic [15:0] base);
    logic [FW*WW-1:0] r;
    for (int unsigned i = 0; i < FW; i++) r[i*WW +: WW] = base + 16'(i);
    return r;
  endfunction

  function automatic logic [FW*WW-1:0] apply_mask(input logic [FW*WW-1:0] d, input logic [FW-1:0] m);
    logic [FW*WW-1:0] r;
    for (int unsigned i = 0; i < FW; i++) r[i*WW +: WW] = m[i] ? d[i*WW +: WW] : 16'h0;
    return r;
  endfunction

  // Model: collect accepted rows; a completed bank yields FW expected columns.
  task automatic push_row(input logic [FW*WW-1:0] row);
    col_t c;
    mrow[mrows] = row;
    mrows++;
    if (mrows == NR) begin
      for (int unsigned k = 0; k < FW; k++) begin
        for (int unsigned r = 0; r < NR; r++) c.pix[r*WW +: WW] = mrow[r][k*WW +: WW];
        c.idx  = CW'(k);
        c.last = (k == FW - 1);
        sb.push_back(c);
      end
      mrows = 0;
    end
  endtask

  task automatic send(input logic [FW*WW-1:0] d, input logic [FW-1:0] m, input logic [FW*WW-1:0] exp_row);
    int unsigned n = 0;
    in_data = d; in_mask = m; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        push_row(exp_row);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        check("accept_timeout", {63'd0, in_ready}, 64'd1);
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check(nm, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("column_unexpected", {63'd0, out_valid}, 64'd0);
      end else begin
        col_t e;
        e = sb.pop_front();
        check("column", 64'({out_pixels, out_col_index, out_last}), 64'({e.pix, e.idx, e.last}));
      end
    end
  end

  initial begin
    int unsigned bubbles;
    int unsigned n;

    tbl[0] = '{{16'd4, 16'd3, 16'd2, 16'd1}, 4'hF, {16'd4, 16'd3, 16'd2, 16'd1}};
    tbl[1] = '{{16'd8, 16'd7, 16'd6, 16'd5}, 4'hF, {16'd8, 16'd7, 16'd6, 16'd5}};
    tbl[2] = '{{16'hD, 16'hC, 16'hB, 16'hA}, 4'b1010, {16'hD, 16'h0, 16'hB, 16'h0}};
    tbl[3] = '{{16'h1114, 16'h1113, 16'h1112, 16'h1111}, 4'hF, {16'h1114, 16'h1113, 16'h1112, 16'h1111}};
    tbl[4] = '{{16'h0044, 16'h0033, 16'h0022, 16'h0011}, 4'b0101, {16'h0, 16'h0033, 16'h0, 16'h0011}};
    tbl[5] = '{{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 4'b0000, {FW*WW{1'b0}}};

    rst = 1'b1; in_data = '0; in_mask = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_col_index", 64'(out_col_index), 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Table vectors: defaults, masking and mask boundaries.
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      send(tbl[i].data, tbl[i].mask, tbl[i].exp_row);
      if (i == 1) begin
        check("first_valid", {63'd0, out_valid}, 64'd1);
        check("first_col0", 64'(out_col_index), 64'd0);
      end
    end
    idle();
    wait_drain("table_drain");

    // Backpressure: both banks fill, column index frozen, release drains.
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 4; k++) send(mkrow(16'h0100 + 16'(k * 16)), 4'hF, mkrow(16'h0100 + 16'(k * 16)));
    idle();
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_col_hold", 64'(out_col_index), 64'd0);
    check("bp_valid_hold", {63'd0, out_valid}, 64'd1);
    check("bp_in_ready_still_low", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_release_in_ready_%0d", k), {63'd0, in_ready}, (k == 3) ? 64'd1 : 64'd0);
    end
    wait_drain("bp_drain");

    // Overlap: continuous input, output must stream without bubbles.
    bubbles = 0;
    fork
      begin
        for (int unsigned k = 0; k < 6; k++) send(mkrow(16'h0200 + 16'(k * 16)), 4'hF, mkrow(16'h0200 + 16'(k * 16)));
        idle();
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        for (int unsigned k = 0; k < 12; k++) begin
          if (k != 0) @(negedge clk);
          if (!out_valid) bubbles++;
        end
      end
    join
    check("overlap_bubbles", 64'(bubbles), 64'd0);
    wait_drain("overlap_drain");

    // Flush: a partial row is discarded and a fresh bank follows.
    send(mkrow(16'hEE00), 4'hF, mkrow(16'hEE00));
    in_data = mkrow(16'hEF00); in_mask = 4'hF; in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; mrows = 0;
    send(mkrow(16'h0300), 4'hF, mkrow(16'h0300));
    send(mkrow(16'h0310), 4'b0110, apply_mask(mkrow(16'h0310), 4'b0110));
    idle();
    wait_drain("flush_drain");

    // Reset while a bank is mid-drain.
    send(mkrow(16'h0400), 4'hF, mkrow(16'h0400));
    send(mkrow(16'h0410), 4'hF, mkrow(16'h0410));
    idle();
    n = 0;
    while (!(out_valid && out_col_index == 2'd2) && n < 50) begin @(posedge clk); #1; n++; end
    check("rst_mid_reach_col2", 64'(out_col_index), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete(); mrows = 0;
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_mid_col_index", 64'(out_col_index), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_in_ready_back", {63'd0, in_ready}, 64'd1);
    send(mkrow(16'h0500), 4'hF, mkrow(16'h0500));
    send(mkrow(16'h0510), 4'hF, mkrow(16'h0510));
    idle();
    check("rst_mid_restart_valid", {63'd0, out_valid}, 64'd1);
    check("rst_mid_restart_col0", 64'(out_col_index), 64'd0);
    wait_drain("rst_mid_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
